pooling_unit: RTL and testbench

Compute stage directly downstream of the pooling input address generator (IAGU) and the IO buffer. It consumes the IO-buffer read data, qualified by the generator's read-enable and end-of-window marker. It reduces each kernel window lane-wise to one value: max, or average when compiled in. Results are written back to the IO buffer at sequential addresses, with a done pulse at the end of the layer.

---
 rtl/pooling_unit.sv | 207 ++++++++++++++++++++
 tb/tb_pooling_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_unit.sv
// Lane-wise max reduction of IAGU-driven pooling windows, written back to the IO buffer.
// Define POOL_AVG_EN to add a selectable average path (adds one output pipeline stage).
module pooling_unit #(
   parameter int unsigned LANES  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_calculate,
   input  logic [ADDR_W-1:0]       addr_start_w,
   input  logic [7:0]              out_x_length,
   input  logic [7:0]              out_y_length,
   input  logic [7:0]              in_piece,
   input  logic [3:0]              i_kernel,
   input  logic                    i_rd_en,
   input  logic                    i_pooling_out,
   input  logic [LANES*DATA_W-1:0] i_data,
   input  logic [15:0]             i_avg_recip,
`ifdef POOL_AVG_EN
   input  logic                    i_avg_mode,
`endif
   output logic [LANES*DATA_W-1:0] o_data,
   output logic                    o_wr_en,
   output logic [ADDR_W-1:0]       o_wr_addr,
   output logic                    o_done,
   output logic                    o_err
);

   localparam int unsigned WORD_W = LANES * DATA_W;
   localparam int unsigned CNT_W  = 24;
   localparam int unsigned KK_W   = 8;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t              state, state_nx;
   logic                rd_d, po_d;
   logic [ADDR_W-1:0]   wr_addr;
   logic [CNT_W-1:0]    out_cnt, total;
   logic [KK_W-1:0]     elem_cnt, kk;
   logic [WORD_W-1:0]   acc;
   logic [WORD_W-1:0]   max_word_c;
   logic [CNT_W-1:0]    total_c;
   logic [KK_W-1:0]     kk_c;
   logic                first_c, load_c, acc_en_c, emit_c;

   assign total_c = CNT_W'(out_x_length) * CNT_W'(out_y_length) * CNT_W'(in_piece);
   assign kk_c    = KK_W'(i_kernel) * KK_W'(i_kernel);
   assign first_c = (elem_cnt == '0);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic; RUN ends on the write that brings out_cnt up to total
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start_calculate) state_nx = (total_c == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (emit_c && (out_cnt + CNT_W'(1) == total)) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      load_c   = 1'b0;
      acc_en_c = 1'b0;
      emit_c   = 1'b0;
      case (state)
         ST_IDLE: load_c = start_calculate;
         ST_RUN: begin
            acc_en_c = rd_d;
            emit_c   = rd_d && po_d;
         end
         default: ;
      endcase
   end

`ifdef POOL_AVG_EN
   localparam int unsigned SUM_W = DATA_W + 8;
   logic [LANES*SUM_W-1:0] sum_q, sum_word_c, p1_sum;
   logic [WORD_W-1:0]      p1_max, avg_word_c;
   logic [ADDR_W-1:0]      p1_addr;
   logic                   p1_vld, done_d, avg_mode;
`else
   logic unused_recip_c;
   assign unused_recip_c = ^i_avg_recip;
`endif

   // Per-lane reductions; the current element is folded in combinationally
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DATA_W-1:0] d, a;
      assign d = i_data[l*DATA_W +: DATA_W];
      assign a = acc[l*DATA_W +: DATA_W];
      assign max_word_c[l*DATA_W +: DATA_W] = (first_c || (d > a)) ? d : a;
`ifdef POOL_AVG_EN
      logic signed [SUM_W-1:0]    s, ps;
      logic signed [SUM_W+16:0]   prod, rnd;
      logic signed [SUM_W:0]      q;
      logic                       ovf;
      logic                       unused_rnd_c;
      assign s    = sum_q[l*SUM_W +: SUM_W];
      assign sum_word_c[l*SUM_W +: SUM_W] = first_c ? SUM_W'(d) : s + SUM_W'(d);
      assign ps   = p1_sum[l*SUM_W +: SUM_W];
      assign prod = ps * $signed({1'b0, i_avg_recip});
      assign rnd  = prod + $signed((SUM_W+17)'(32'h8000));
      assign q    = rnd[SUM_W+16:16];
      assign unused_rnd_c = ^rnd[15:0];
      assign ovf  = !((&q[SUM_W:DATA_W-1]) || !(|q[SUM_W:DATA_W-1]));
      assign avg_word_c[l*DATA_W +: DATA_W] =
         !ovf     ? q[DATA_W-1:0] :
         q[SUM_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
   end

   // Layer bookkeeping and window accumulation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_d     <= 1'b0;
         po_d     <= 1'b0;
         wr_addr  <= '0;
         out_cnt  <= '0;
         total    <= '0;
         elem_cnt <= '0;
         kk       <= '0;
         acc      <= '0;
         o_err    <= 1'b0;
      end else begin
         rd_d <= i_rd_en;
         po_d <= i_rd_en && i_pooling_out;
         if (load_c) begin
            wr_addr  <= addr_start_w;
            out_cnt  <= '0;
            elem_cnt <= '0;
            total    <= total_c;
            kk       <= kk_c;
            o_err    <= 1'b0;
         end
         if (acc_en_c) begin
            acc      <= max_word_c;
            elem_cnt <= emit_c ? '0 : elem_cnt + KK_W'(1);
            if (emit_c && (elem_cnt + KK_W'(1) != kk)) o_err <= 1'b1;
         end
         if (emit_c) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            out_cnt <= out_cnt + CNT_W'(1);
         end
      end
   end

`ifdef POOL_AVG_EN
   // Extra stage: window result held one cycle while the average is scaled and saturated
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         avg_mode  <= 1'b0;
         sum_q     <= '0;
         p1_vld    <= 1'b0;
         p1_addr   <= '0;
         p1_max    <= '0;
         p1_sum    <= '0;
         done_d    <= 1'b0;
         o_wr_en   <= 1'b0;
         o_data    <= '0;
         o_wr_addr <= '0;
         o_done    <= 1'b0;
      end else begin
         if (load_c)   avg_mode <= i_avg_mode;
         if (acc_en_c) sum_q    <= sum_word_c;
         p1_vld <= emit_c;
         if (emit_c) begin
            p1_addr <= wr_addr;
            p1_max  <= max_word_c;
            p1_sum  <= sum_word_c;
         end
         o_wr_en <= p1_vld;
         if (p1_vld) begin
            o_data    <= avg_mode ? avg_word_c : p1_max;
            o_wr_addr <= p1_addr;
         end
         done_d <= (state == ST_DONE);
         o_done <= done_d;
      end
   end
`else
   // Result write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_wr_en   <= 1'b0;
         o_data    <= '0;
         o_wr_addr <= '0;
         o_done    <= 1'b0;
      end else begin
         o_wr_en <= emit_c;
         if (emit_c) begin
            o_data    <= max_word_c;
            o_wr_addr <= wr_addr;
         end
         o_done <= (state == ST_DONE);
      end
   end
`endif

endmodule

// File: tb/tb_pooling_unit.sv
// Directed self-checking bench for pooling_unit (max path; average path when POOL_AVG_EN).
module tb_pooling_unit;
   localparam int unsigned LANES  = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned WORD_W = LANES * DATA_W;
`ifdef POOL_AVG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic              clk;
   logic              rst;
   logic              start_calculate;
   logic [ADDR_W-1:0] addr_start_w;
   logic [7:0]        out_x_length, out_y_length, in_piece;
   logic [3:0]        i_kernel;
   logic              i_rd_en, i_pooling_out;
   logic [WORD_W-1:0] i_data;
   logic [15:0]       i_avg_recip;
`ifdef POOL_AVG_EN
   logic              i_avg_mode;
`endif
   logic [WORD_W-1:0] o_data;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic              o_done, o_err;

   pooling_unit #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start_calculate(start_calculate), .addr_start_w(addr_start_w),
      .out_x_length(out_x_length), .out_y_length(out_y_length), .in_piece(in_piece),
      .i_kernel(i_kernel), .i_rd_en(i_rd_en), .i_pooling_out(i_pooling_out), .i_data(i_data),
      .i_avg_recip(i_avg_recip),
`ifdef POOL_AVG_EN
      .i_avg_mode(i_avg_mode),
`endif
      .o_data(o_data), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_done(o_done), .o_err(o_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int                wq_cyc[$];
   logic [ADDR_W-1:0] wq_addr[$];
   logic [WORD_W-1:0] wq_data[$];
   int                dq_cyc[$];
   int                po_cyc[$];

   // Write/done capture, sampled mid-cycle
   always @(negedge clk) begin
      if (o_wr_en) begin
         wq_cyc.push_back(cyc);
         wq_addr.push_back(o_wr_addr);
         wq_data.push_back(o_data);
      end
      if (o_done) dq_cyc.push_back(cyc);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // IO-buffer model: data for a read appears on i_data the following cycle
   logic [WORD_W-1:0] pend = '0;
   task automatic drive(input logic rd, input logic po, input logic [WORD_W-1:0] d);
      i_rd_en       = rd;
      i_pooling_out = po;
      i_data        = pend;
      pend          = d;
      if (rd && po) po_cyc.push_back(cyc);
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0);
   endtask

   int start_cyc;
   task automatic start_layer(input int k, input int ox, input int oy, input int ip,
                              input int addr, input logic avgm);
      i_kernel        = 4'(k);
      out_x_length    = 8'(ox);
      out_y_length    = 8'(oy);
      in_piece        = 8'(ip);
      addr_start_w    = ADDR_W'(addr);
`ifdef POOL_AVG_EN
      i_avg_mode      = avgm;
`else
      if (avgm) $display("note: average mode requested without POOL_AVG_EN");
`endif
      start_calculate = 1'b1;
      start_cyc       = cyc;
      step();
      start_calculate = 1'b0;
   endtask

   task automatic clear_q();
      wq_cyc.delete(); wq_addr.delete(); wq_data.delete();
      dq_cyc.delete(); po_cyc.delete();
   endtask

   task automatic check_writes(input string tag, input int n, input int base);
      chk({tag, " count"}, 64'(wq_cyc.size()), 64'(n));
      for (int i = 0; i < n && i < wq_cyc.size() && i < po_cyc.size(); i++) begin
         chk($sformatf("%s addr%0d", tag, i), 64'(wq_addr[i]), 64'(ADDR_W'(base + i)));
         chk($sformatf("%s lat%0d", tag, i), 64'(wq_cyc[i] - po_cyc[i]), 64'(LAT));
      end
   endtask

   task automatic check_done(input string tag);
      chk({tag, " done count"}, 64'(dq_cyc.size()), 64'd1);
      if (dq_cyc.size() > 0 && wq_cyc.size() > 0)
         chk({tag, " done timing"}, 64'(dq_cyc[0] - wq_cyc[wq_cyc.size()-1]), 64'd1);
   endtask

   logic [WORD_W-1:0] w, exp_w;
   logic [7:0]        v;
   int                last_n;

   initial begin
      rst = 1'b0; start_calculate = 1'b0; addr_start_w = '0;
      out_x_length = '0; out_y_length = '0; in_piece = '0; i_kernel = '0;
      i_rd_en = 1'b0; i_pooling_out = 1'b0; i_data = '0; i_avg_recip = 16'd7282;
`ifdef POOL_AVG_EN
      i_avg_mode = 1'b0;
`endif
      repeat (3) step();
      chk("rst o_data", 64'(o_data), 64'd0);
      chk("rst o_wr_en", 64'(o_wr_en), 64'd0);
      chk("rst o_wr_addr", 64'(o_wr_addr), 64'd0);
      chk("rst o_done", 64'(o_done), 64'd0);
      chk("rst o_err", 64'(o_err), 64'd0);
      rst = 1'b1;
      idle(2);

      // Max, K=3, 4x2x2 windows streamed back-to-back; lane0 is a permutation of 1..9
      clear_q();
      start_layer(3, 4, 2, 2, 'h100, 1'b0);
      for (int wi = 0; wi < 16; wi++)
         for (int e = 0; e < 9; e++) begin
            w[7:0] = 8'(((e * 4 + wi) % 9) + 1);
            for (int l = 1; l < 8; l++) w[l*8 +: 8] = (e == wi % 9) ? 8'(l * 10) : 8'(l);
            drive(1'b1, e == 8, w);
         end
      idle(6);
      exp_w[7:0] = 8'd9;
      for (int l = 1; l < 8; l++) exp_w[l*8 +: 8] = 8'(l * 10);
      check_writes("k3", 16, 'h100);
      for (int i = 0; i < 16 && i < wq_data.size(); i++)
         chk($sformatf("k3 data%0d", i), wq_data[i], exp_w);
      check_done("k3");
      chk("k3 o_err", 64'(o_err), 64'd0);

      // Signed compare: -128..-120 shuffled, then a window of all -128
      clear_q();
      start_layer(3, 1, 1, 2, 'h200, 1'b0);
      for (int e = 0; e < 9; e++) begin
         v = 8'(-128 + ((e * 2) % 9));
         drive(1'b1, e == 8, {8{v}});
      end
      for (int e = 0; e < 9; e++) drive(1'b1, e == 8, {8{8'h80}});
      idle(6);
      check_writes("sgn", 2, 'h200);
      if (wq_data.size() > 1) begin
         chk("sgn data0", wq_data[0], {8{8'h88}});
         chk("sgn data1", wq_data[1], {8{8'h80}});
      end
      check_done("sgn");

      // Back-to-back K=2 windows: one write every 4 cycles
      clear_q();
      start_layer(2, 3, 1, 1, 'h300, 1'b0);
      for (int wi = 0; wi < 3; wi++)
         for (int e = 0; e < 4; e++) drive(1'b1, e == 3, {8{8'(wi * 10 + 3 - e)}});
      idle(6);
      check_writes("b2b", 3, 'h300);
      for (int i = 0; i < 3 && i < wq_data.size(); i++)
         chk($sformatf("b2b data%0d", i), wq_data[i], {8{8'(i * 10 + 3)}});
      for (int i = 1; i < 3 && i < wq_cyc.size(); i++)
         chk($sformatf("b2b gap%0d", i), 64'(wq_cyc[i] - wq_cyc[i-1]), 64'd4);
      check_done("b2b");

      // Short window: marker after 8 elements with K=3
      clear_q();
      start_layer(3, 1, 1, 1, 'h050, 1'b0);
      for (int e = 0; e < 8; e++) drive(1'b1, e == 7, {8{8'(e + 1)}});
      idle(6);
      check_writes("err", 1, 'h050);
      if (wq_data.size() > 0) chk("err data", wq_data[0], {8{8'd8}});
      chk("err flag", 64'(o_err), 64'd1);
      idle(3);
      chk("err sticky", 64'(o_err), 64'd1);

      // total=0 layer: clears o_err, done with no writes
      clear_q();
      start_layer(3, 4, 0, 2, 'h010, 1'b0);
      chk("zero o_err clr", 64'(o_err), 64'd0);
      idle(5);
      chk("zero writes", 64'(wq_cyc.size()), 64'd0);
      chk("zero done count", 64'(dq_cyc.size()), 64'd1);
      if (dq_cyc.size() > 0) chk("zero done timing", 64'(dq_cyc[0] - start_cyc), 64'(LAT));

      // Reset mid-layer after 5 writes, then a fresh layer
      clear_q();
      start_layer(2, 2, 2, 2, 'h040, 1'b0);
      for (int wi = 0; wi < 6; wi++)
         for (int e = 0; e < 4; e++) drive(1'b1, e == 3, {8{8'(wi + e + 1)}});
      chk("mid writes", 64'(wq_cyc.size()), 64'd5);
      rst = 1'b0; i_rd_en = 1'b0; i_pooling_out = 1'b0;
      #1;
      chk("mid o_data", 64'(o_data), 64'd0);
      chk("mid o_wr_en", 64'(o_wr_en), 64'd0);
      chk("mid o_wr_addr", 64'(o_wr_addr), 64'd0);
      chk("mid o_done", 64'(o_done), 64'd0);
      step(); step();
      rst = 1'b1; pend = '0;
      idle(3);
      last_n = wq_cyc.size();
      chk("mid no late write", 64'(last_n), 64'd5);
      clear_q();
      start_layer(2, 2, 1, 1, 'h060, 1'b0);
      for (int wi = 0; wi < 2; wi++)
         for (int e = 0; e < 4; e++) drive(1'b1, e == 3, {8{8'(8'h70 - 8'(e * 3 + wi))}});
      idle(6);
      check_writes("post", 2, 'h060);
      if (wq_data.size() > 1) begin
         chk("post data0", wq_data[0], {8{8'h70}});
         chk("post data1", wq_data[1], {8{8'h6F}});
      end
      check_done("post");

`ifdef POOL_AVG_EN
      // Average: all-10 and all -7 windows, K=3
      clear_q();
      start_layer(3, 1, 1, 2, 'h080, 1'b1);
      for (int e = 0; e < 9; e++) drive(1'b1, e == 8, {8{8'd10}});
      for (int e = 0; e < 9; e++) drive(1'b1, e == 8, {8{8'hF9}});
      idle(6);
      check_writes("avg", 2, 'h080);
      if (wq_data.size() > 1) begin
         chk("avg data0", wq_data[0], {8{8'd10}});
         chk("avg data1", wq_data[1], {8{8'hF9}});
      end
      check_done("avg");
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
